// File: rtl/des_pkg.sv
`default_nettype none
// ============================================================================
// Module   : des_pkg
// Brief    : Shared DES key-schedule constants (PC-1, PC-2, shift schedule),
//            state encoding and helper functions.
// Revision : 1.0 - initial release
// ============================================================================
package des_pkg;

    localparam int c_key_w    = 64;
    localparam int c_subkey_w = 48;
    localparam int c_half_w   = 28;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } ks_state_t;

    // Table entries use DES numbering: bit 1 is the MSB of the source vector.
    localparam int c_pc1_table [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int c_pc2_table [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // Two bits per round, round 1 in the least significant slot.
    localparam logic [31:0] c_shift_sched = {
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1,
        2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1
    };

    // idx is the zero-based round number (0 -> round 1).
    function automatic logic [1:0] shift_of(input logic [3:0] idx);
        return c_shift_sched[{idx, 1'b0} +: 2];
    endfunction

    function automatic logic [2*c_half_w-1:0] pc1(input logic [c_key_w-1:0] key);
        logic [2*c_half_w-1:0] r;
        r = '0;
        for (int i = 0; i < 2*c_half_w; i++) begin
            r[2*c_half_w-1-i] = key[c_key_w - c_pc1_table[i]];
        end
        return r;
    endfunction

    function automatic logic [c_half_w-1:0] rot28(input logic [c_half_w-1:0] x,
                                                  input logic [1:0]          amt,
                                                  input logic                right);
        logic [c_half_w-1:0] r;
        if (right) begin
            r = (amt == 2'd2) ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
        end else begin
            r = (amt == 2'd2) ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
        end
        return r;
    endfunction

    function automatic logic key_odd_parity(input logic [c_key_w-1:0] key);
        logic ok;
        ok = 1'b1;
        for (int b = 0; b < 8; b++) begin
            ok = ok & (^key[8*b +: 8]);
        end
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/des_pc2.sv
`default_nettype none
// ============================================================================
// Module   : des_pc2
// Brief    : Combinational DES Permuted Choice 2, C||D (56b) -> subkey (48b).
// Revision : 1.0 - initial release
// ============================================================================
module des_pc2
    import des_pkg::*;
(
    input  logic [2*c_half_w-1:0] cd,
    output logic [c_subkey_w-1:0] subkey
);

    generate
        for (genvar i = 0; i < c_subkey_w; i++) begin : g_pc2
            assign subkey[c_subkey_w-1-i] = cd[2*c_half_w - c_pc2_table[i]];
        end
    endgenerate

    // PC-2 discards DES bits 9, 18, 22, 25, 35, 38, 43 and 54.
    logic w_unused_dropped;
    assign w_unused_dropped = ^{cd[47], cd[38], cd[34], cd[31],
                                cd[21], cd[18], cd[13], cd[2]};

endmodule
`default_nettype wire

// File: rtl/des_key_schedule.sv
`default_nettype none
// ============================================================================
// Module   : des_key_schedule
// Brief    : Iterative DES subkey generator, one 48-bit subkey per handshake,
//            encrypt or decrypt order. Option: DES_KS_PARITY_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module des_key_schedule
    import des_pkg::*;
#(
    parameter int NUM_ROUNDS = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  decrypt,
    input  logic [c_key_w-1:0]    key_in,
    output logic [c_subkey_w-1:0] subkey,
    output logic                  subkey_valid,
    input  logic                  subkey_ready,
    output logic [3:0]            round_idx,
    output logic                  last,
    output logic                  busy,
    output logic                  done,
    output logic                  parity_err
);

    localparam logic [3:0] c_last_idx = 4'(NUM_ROUNDS - 1);

    generate
        if (NUM_ROUNDS != 16) begin : g_bad_num_rounds
            $error("des_key_schedule: NUM_ROUNDS must be 16");
        end
    endgenerate

    ks_state_t             r_state;
    ks_state_t             w_next_state;
    logic [c_half_w-1:0]   r_c;
    logic [c_half_w-1:0]   r_d;
    logic [3:0]            r_cnt;
    logic                  r_dec;
    logic [2*c_half_w-1:0] w_pc1;
    logic [1:0]            w_shift;
    logic                  w_key_ok;
    logic                  w_accept;
    logic                  w_handshake;
    logic                  w_at_last;

`ifdef DES_KS_PARITY_CHECK_EN
    logic r_parity_err;

    assign w_key_ok = key_odd_parity(key_in);

    // Every start seen in IDLE re-evaluates the flag, pass or fail.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_parity_err <= 1'b0;
        end else if (r_state == ST_IDLE && start) begin
            r_parity_err <= !w_key_ok;
        end
    end

    assign parity_err = r_parity_err;
`else
    logic w_unused_parity;

    assign w_key_ok        = 1'b1;
    assign parity_err      = 1'b0;
    assign w_unused_parity = ^key_in;
`endif

    assign w_pc1       = pc1(key_in);
    assign w_accept    = (r_state == ST_IDLE) && start && w_key_ok;
    assign w_handshake = subkey_valid && subkey_ready;
    assign w_at_last   = (r_cnt == c_last_idx);
    // Step from the current round to the next one in emission order.
    assign w_shift     = r_dec ? shift_of(4'd15 - r_cnt) : shift_of(r_cnt + 4'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_next_state = ST_RUN;
            ST_RUN:  if (w_handshake && w_at_last) w_next_state = ST_DONE;
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Decrypt starts from the unrotated halves: C16/D16 equal C0/D0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_c   <= '0;
            r_d   <= '0;
            r_cnt <= 4'd0;
            r_dec <= 1'b0;
        end else if (w_accept) begin
            r_c   <= decrypt ? w_pc1[55:28] : rot28(w_pc1[55:28], 2'd1, 1'b0);
            r_d   <= decrypt ? w_pc1[27:0]  : rot28(w_pc1[27:0],  2'd1, 1'b0);
            r_cnt <= 4'd0;
            r_dec <= decrypt;
        end else if (w_handshake && !w_at_last) begin
            r_c   <= rot28(r_c, w_shift, r_dec);
            r_d   <= rot28(r_d, w_shift, r_dec);
            r_cnt <= r_cnt + 4'd1;
        end
    end

    des_pc2 u_pc2 (
        .cd     ({r_c, r_d}),
        .subkey (subkey)
    );

    assign subkey_valid = (r_state == ST_RUN);
    assign busy         = (r_state == ST_RUN);
    assign done         = (r_state == ST_DONE);
    assign last         = subkey_valid && w_at_last;
    assign round_idx    = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_des_key_schedule.sv
`default_nettype none
// ============================================================================
// Module   : tb_des_key_schedule
// Brief    : Directed self-checking bench for des_key_schedule.
// Revision : 1.0 - initial release
// ============================================================================
module tb_des_key_schedule;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        decrypt;
    logic [63:0] key_in;
    logic [47:0] subkey;
    logic        subkey_valid;
    logic        subkey_ready;
    logic [3:0]  round_idx;
    logic        last;
    logic        busy;
    logic        done;
    logic        parity_err;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [63:0] c_key = 64'h133457799BBCDFF1;

    // Known-answer subkeys K1..K16 for c_key.
    logic [47:0] k_exp [16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };

    des_key_schedule #(.NUM_ROUNDS(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .decrypt      (decrypt),
        .key_in       (key_in),
        .subkey       (subkey),
        .subkey_valid (subkey_valid),
        .subkey_ready (subkey_ready),
        .round_idx    (round_idx),
        .last         (last),
        .busy         (busy),
        .done         (done),
        .parity_err   (parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns one cycle after the start edge, i.e. with the first subkey visible.
    task automatic do_start(input logic [63:0] key, input logic dec);
        key_in  = key;
        decrypt = dec;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    // Walks all 16 handshakes; ends in the DONE cycle.
    task automatic run_sched(input string tag, input logic dec, input logic zero,
                             input int stall_at, input int poke_at);
        for (int i = 0; i < 16; i++) begin
            int          e;
            logic [47:0] exp_k;
            e     = dec ? 15 - i : i;
            exp_k = zero ? 48'h0 : k_exp[e];
            check({tag, "_valid"}, 64'(subkey_valid), 64'(1'b1));
            check({tag, "_busy"},  64'(busy),         64'(1'b1));
            check({tag, "_subkey"}, 64'(subkey),      64'(exp_k));
            check({tag, "_idx"},   64'(round_idx),    64'(i));
            check({tag, "_last"},  64'(last),         64'(i == 15));
            if (i == stall_at) begin
                subkey_ready = 1'b0;
                repeat (5) begin
                    tick();
                    check({tag, "_stall_subkey"}, 64'(subkey),       64'(exp_k));
                    check({tag, "_stall_idx"},    64'(round_idx),    64'(i));
                    check({tag, "_stall_valid"},  64'(subkey_valid), 64'(1'b1));
                end
                subkey_ready = 1'b1;
            end
            if (i == poke_at) begin
                key_in  = 64'hFEDCBA9876543210;
                decrypt = ~dec;
                start   = 1'b1;
            end
            tick();
            if (i == poke_at) start = 1'b0;
        end
        check({tag, "_done"},       64'(done),         64'(1'b1));
        check({tag, "_done_valid"}, 64'(subkey_valid), 64'(1'b0));
        check({tag, "_done_busy"},  64'(busy),         64'(1'b0));
        check({tag, "_done_last"},  64'(last),         64'(1'b0));
    endtask

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        decrypt      = 1'b0;
        key_in       = '0;
        subkey_ready = 1'b1;
        repeat (3) tick();

        check("rst_valid",  64'(subkey_valid), 64'(1'b0));
        check("rst_busy",   64'(busy),         64'(1'b0));
        check("rst_done",   64'(done),         64'(1'b0));
        check("rst_last",   64'(last),         64'(1'b0));
        check("rst_idx",    64'(round_idx),    64'(0));
        check("rst_subkey", 64'(subkey),       64'(0));
        check("rst_perr",   64'(parity_err),   64'(1'b0));
        rst_n = 1'b1;
        tick();

        // Encrypt, full throughput; start pulsed in the DONE cycle is ignored.
        do_start(c_key, 1'b0);
        run_sched("enc", 1'b0, 1'b0, -1, -1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("done_pulse",     64'(done),         64'(1'b0));
        check("done_start_ign", 64'(subkey_valid), 64'(1'b0));
        tick();
        check("idle_valid",     64'(subkey_valid), 64'(1'b0));
        check("idle_busy",      64'(busy),         64'(1'b0));

        do_start(c_key, 1'b1);
        run_sched("dec", 1'b1, 1'b0, -1, -1);
        tick();

        do_start(c_key, 1'b0);
        run_sched("bp", 1'b0, 1'b0, 3, -1);
        tick();

        do_start(c_key, 1'b0);
        run_sched("poke", 1'b0, 1'b0, -1, 5);
        tick();

        // Asynchronous reset in the middle of a schedule.
        do_start(c_key, 1'b0);
        repeat (7) tick();
        check("mid_idx", 64'(round_idx), 64'(7));
        rst_n = 1'b0;
        #1;
        check("arst_valid",  64'(subkey_valid), 64'(1'b0));
        check("arst_busy",   64'(busy),         64'(1'b0));
        check("arst_idx",    64'(round_idx),    64'(0));
        check("arst_subkey", 64'(subkey),       64'(0));
        tick();
        rst_n = 1'b1;
        tick();
        do_start(c_key, 1'b0);
        run_sched("after_rst", 1'b0, 1'b0, -1, -1);
        tick();

`ifdef DES_KS_PARITY_CHECK_EN
        do_start(64'h0, 1'b0);
        check("perr_set",   64'(parity_err),   64'(1'b1));
        check("perr_valid", 64'(subkey_valid), 64'(1'b0));
        check("perr_busy",  64'(busy),         64'(1'b0));
        tick();
        check("perr_sticky", 64'(parity_err),   64'(1'b1));
        check("perr_idle",   64'(subkey_valid), 64'(1'b0));
        do_start(c_key, 1'b0);
        check("perr_clear", 64'(parity_err), 64'(1'b0));
        run_sched("perr_good", 1'b0, 1'b0, -1, -1);
        tick();
`else
        do_start(64'h0, 1'b0);
        check("zero_perr", 64'(parity_err), 64'(1'b0));
        run_sched("zero", 1'b0, 1'b1, -1, -1);
        tick();
        do_start(c_key, 1'b0);
        check("zero_then_k1", 64'(subkey), 64'(k_exp[0]));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
